wasm_cmp_stack: RTL and testbench

Parametrised operand stack with a built-in WebAssembly comparison unit. It covers eqz/eq/ne/lt/gt/le/ge in signed and unsigned forms, for both i32 and i64.
It sits beside the core's instruction decoder. The decoder issues push, pop and compare commands over a valid/ready handshake. The block exposes top-of-stack as result/result_empty and raises sticky traps, using the same conventions as the core.

---
 rtl/wasm_cmp_stack.sv | 136 +++++++++++++
 tb/tb_wasm_cmp_stack.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_cmp_stack.sv
// Operand stack with a WebAssembly i32/i64 comparison unit.
// TOS lives in a register; the entries below it live in a synchronous-read RAM.
module wasm_cmp_stack #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_is64,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] result,
  output logic             result_empty,
  output logic [CW-1:0]    depth,
  output logic [3:0]       trap,
  output logic             fsm_state
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

  localparam logic [3:0] OP_PUSH  = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_EQZ   = 4'd3;
  localparam logic [3:0] OP_CLEAR = 4'd14;
  localparam logic [3:0] OP_BAD   = 4'd15;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] ram [DEPTH-1];
  logic [3:0]       op_q;
  logic             is64_q;

  logic          accept, is_cmp, is_full, is_zero, cmp_bit;
  logic          ram_we, ram_re;
  logic [3:0]    trap_code;
  logic [AW-1:0] wr_addr, rd_addr;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // ready drops while a two-cycle command waits in FETCH and stays low once trapped.
  assign cmd_ready    = (state == IDLE) && (trap == 4'd0);
  assign accept       = cmd_valid && cmd_ready;
  assign result_empty = (depth == '0);
  assign result       = (depth != '0) ? tos : '0;
  assign fsm_state    = state;

  assign is_cmp  = (cmd_op >= 4'd4) && (cmd_op <= 4'd13);
  assign is_full = (depth == CW'(DEPTH));
  assign is_zero = cmd_is64 ? (tos[63:0] == 64'd0) : (tos[31:0] == 32'd0);
  assign wr_addr = AW'(depth - CW'(1));
  assign rd_addr = AW'(depth - CW'(2));

  // Both operands are extended to 65 bits so one signed compare covers all forms.
  function automatic logic cmp_fn(input logic [3:0] op, input logic is64,
                                  input logic [63:0] a, input logic [63:0] b);
    logic               sgn, eq, lt;
    logic signed [64:0] ax, bx;
    sgn = ~op[0];
    ax  = is64 ? {sgn & a[63], a} : {{33{sgn & a[31]}}, a[31:0]};
    bx  = is64 ? {sgn & b[63], b} : {{33{sgn & b[31]}}, b[31:0]};
    eq  = (ax == bx);
    lt  = (ax < bx);
    case (op)
      4'd4:         cmp_fn = eq;
      4'd5:         cmp_fn = !eq;
      4'd6, 4'd7:   cmp_fn = lt;
      4'd8, 4'd9:   cmp_fn = !lt && !eq;
      4'd10, 4'd11: cmp_fn = lt || eq;
      4'd12, 4'd13: cmp_fn = !lt;
      default:      cmp_fn = 1'b0;
    endcase
  endfunction

  assign cmp_bit = cmp_fn(op_q, is64_q, rd_data[63:0], tos[63:0]);

  always_comb begin
    trap_code = 4'd0;
    if (cmd_op == OP_BAD)                                trap_code = 4'd3;
    else if (cmd_op == OP_PUSH && is_full)               trap_code = 4'd2;
    else if ((cmd_op == OP_POP || cmd_op == OP_EQZ) && depth == '0) trap_code = 4'd1;
    else if (is_cmp && depth < CW'(2))                   trap_code = 4'd1;
  end

  assign ram_we = accept && (cmd_op == OP_PUSH) && (depth != '0) && !is_full;
  assign ram_re = accept && (trap_code == 4'd0) && (cmd_op == OP_POP || is_cmp)
                  && (depth >= CW'(2));

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_addr] <= tos;
    if (ram_re) rd_data <= ram[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tos    <= '0;
      depth  <= '0;
      trap   <= 4'd0;
      op_q   <= 4'd0;
      is64_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (trap_code != 4'd0) begin
              trap <= trap_code;
            end else if (cmd_op == OP_PUSH) begin
              tos   <= push_data;
              depth <= depth + CW'(1);
            end else if (cmd_op == OP_EQZ) begin
              tos <= WIDTH'(is_zero);
            end else if (cmd_op == OP_CLEAR) begin
              depth <= '0;
            end else if (cmd_op == OP_POP || is_cmp) begin
              op_q   <= cmd_op;
              is64_q <= cmd_is64;
              state  <= FETCH;
            end
          end
        end
        FETCH: begin
          tos   <= (op_q == OP_POP) ? rd_data : WIDTH'(cmp_bit);
          depth <= depth - CW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_cmp_stack.sv
// Directed bench for wasm_cmp_stack: the driver queues expected snapshots,
// a negedge monitor pops and compares them when the strobe is raised.
module tb_wasm_cmp_stack;
  localparam int WIDTH = 64;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int EW    = 1 + 1 + 4 + CW + 1 + WIDTH;

  localparam logic [3:0] NOP = 0, PUSH = 1, POP = 2, EQZ = 3, EQ = 4, NE = 5,
    LT_S = 6, LT_U = 7, GT_S = 8, GT_U = 9, LE_S = 10, LE_U = 11, GE_S = 12,
    GE_U = 13, CLEAR = 14, BAD = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [3:0]       cmd_op = 4'd0;
  logic             cmd_is64 = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic [WIDTH-1:0] result;
  logic             result_empty;
  logic [CW-1:0]    depth;
  logic [3:0]       trap;
  logic             fsm_state;

  wasm_cmp_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_is64(cmd_is64), .push_data(push_data),
    .result(result), .result_empty(result_empty), .depth(depth),
    .trap(trap), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [EW-1:0]    exp_q[$];
  string            name_q[$];
  logic             strobe = 1'b0;

  function automatic logic [EW-1:0] pack(logic st, logic rdy, logic [3:0] tr,
                                         logic [CW-1:0] dep, logic emp,
                                         logic [WIDTH-1:0] res);
    return {st, rdy, tr, dep, emp, res};
  endfunction

  always @(negedge clk) begin
    if (strobe) begin
      logic [EW-1:0] e, a;
      string nm;
      a = pack(fsm_state, cmd_ready, trap, depth, result_empty, result);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL monitor: strobe with empty expected queue");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got res=%h dep=%0d trap=%0d rdy=%b emp=%b st=%b, want res=%h dep=%0d trap=%0d rdy=%b emp=%b st=%b",
                   nm, a[WIDTH-1:0], a[WIDTH+CW:WIDTH+1], a[EW-3:EW-6], a[EW-2], a[WIDTH], a[EW-1],
                   e[WIDTH-1:0], e[WIDTH+CW:WIDTH+1], e[EW-3:EW-6], e[EW-2], e[WIDTH], e[EW-1]);
        end
      end
    end
  end

  // driver tasks
  task automatic expect_st(string nm, logic [WIDTH-1:0] res, int dep, int tr,
                           logic rdy, logic st = 1'b0);
    exp_q.push_back(pack(st, rdy, tr[3:0], dep[CW-1:0], dep == 0, res));
    name_q.push_back(nm);
    strobe = 1'b1;
    @(negedge clk);
    #1 strobe = 1'b0;
  endtask

  task automatic do_cmd(logic [3:0] op, logic is64 = 1'b1, logic [WIDTH-1:0] data = '0);
    int n;
    @(negedge clk);
    cmd_op    = op;
    cmd_is64  = is64;
    push_data = data;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_timeout: op=%0d cmd_ready stayed %b, want 1", op, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    if (op == POP || (op >= EQ && op <= GE_U)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic bin_case(string nm, logic [3:0] op, logic is64,
                          logic [WIDTH-1:0] c1, logic [WIDTH-1:0] c2, logic [WIDTH-1:0] r);
    do_cmd(CLEAR);
    do_cmd(PUSH, 1'b1, c1);
    do_cmd(PUSH, 1'b1, c2);
    do_cmd(op, is64);
    expect_st(nm, r, 1, 0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    expect_st("reset_state", 0, 0, 0, 1'b1);

    // i64 equality
    do_cmd(PUSH, 1'b1, 64'd5);
    expect_st("push_first", 64'd5, 1, 0, 1'b1);
    do_cmd(PUSH, 1'b1, 64'd5);
    do_cmd(EQ, 1'b1);
    expect_st("eq64_equal", 64'd1, 1, 0, 1'b1);
    do_cmd(PUSH, 1'b1, 64'd5);
    do_cmd(PUSH, 1'b1, 64'd6);
    do_cmd(EQ, 1'b1);
    expect_st("eq64_differ", 64'd0, 2, 0, 1'b1);
    do_cmd(NE, 1'b1);
    expect_st("ne64_1_vs_0", 64'd1, 1, 0, 1'b1);
    do_cmd(NOP);
    expect_st("nop_no_effect", 64'd1, 1, 0, 1'b1);
    do_cmd(CLEAR);
    expect_st("clear", 0, 0, 0, 1'b1);

    // width mode
    bin_case("eq32_upper_ignored", EQ, 1'b0, 64'hFFFFFFFF_00000001, 64'h1, 64'd1);
    bin_case("eq64_upper_counts", EQ, 1'b1, 64'hFFFFFFFF_00000001, 64'h1, 64'd0);

    // signedness
    bin_case("lt_s64_neg", LT_S, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'd1);
    bin_case("lt_u64_big", LT_U, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 64'd0);
    bin_case("lt_s32_min", LT_S, 1'b0, 64'h80000000, 64'h0, 64'd1);
    bin_case("gt_u32_min", GT_U, 1'b0, 64'h80000000, 64'h0, 64'd1);
    bin_case("gt_s64_pos", GT_S, 1'b1, 64'h7FFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 64'd1);
    bin_case("lt_s32_upper_ign", LT_S, 1'b0, 64'h00000000_FFFFFFFF, 64'h7FFFFFFF_00000000, 64'd1);
    bin_case("le_s32_equal_low", LE_S, 1'b0, 64'h1_00000005, 64'h5, 64'd1);
    bin_case("le_u64_greater", LE_U, 1'b1, 64'h1_00000005, 64'h5, 64'd0);
    bin_case("ge_u64_less", GE_U, 1'b1, 64'h5, 64'h1_00000005, 64'd0);
    bin_case("ge_s64_equal", GE_S, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1);

    // POP / EQZ / reset during FETCH
    do_cmd(CLEAR);
    do_cmd(PUSH, 1'b1, 64'd7);
    do_cmd(PUSH, 1'b1, 64'd0);
    do_cmd(EQZ, 1'b1);
    expect_st("eqz64_zero", 64'd1, 2, 0, 1'b1);
    do_cmd(POP);
    expect_st("pop_restores", 64'd7, 1, 0, 1'b1);
    do_cmd(PUSH, 1'b1, 64'h1_00000000);
    do_cmd(EQZ, 1'b0);
    expect_st("eqz32_upper_ign", 64'd1, 2, 0, 1'b1);
    do_cmd(POP);
    do_cmd(PUSH, 1'b1, 64'h1_00000000);
    do_cmd(EQZ, 1'b1);
    expect_st("eqz64_nonzero", 64'd0, 2, 0, 1'b1);
    do_cmd(POP);
    do_cmd(PUSH, 1'b1, 64'd3);
    @(negedge clk);
    cmd_op = POP;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    reset = 1'b1;
    expect_st("pop_in_fetch", 64'd3, 2, 0, 1'b0, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    expect_st("reset_mid_fetch", 0, 0, 0, 1'b1);

    // underflow and recovery
    do_cmd(PUSH, 1'b1, 64'd1);
    do_cmd(GE_U, 1'b1);
    expect_st("underflow_cmp", 64'd1, 1, 1, 1'b0);
    apply_reset();
    expect_st("underflow_reset", 0, 0, 0, 1'b1);
    do_cmd(POP);
    expect_st("underflow_pop", 0, 0, 1, 1'b0);
    apply_reset();
    do_cmd(BAD);
    expect_st("invalid_op", 0, 0, 3, 1'b0);
    apply_reset();

    // fill to DEPTH, then overflow
    for (int i = 1; i <= DEPTH; i++) do_cmd(PUSH, 1'b1, WIDTH'(i));
    expect_st("full_stack", WIDTH'(DEPTH), DEPTH, 0, 1'b1);
    do_cmd(POP);
    expect_st("pop_from_full", WIDTH'(DEPTH - 1), DEPTH - 1, 0, 1'b1);
    do_cmd(PUSH, 1'b1, WIDTH'(DEPTH));
    do_cmd(PUSH, 1'b1, 64'd99);
    expect_st("overflow", WIDTH'(DEPTH), DEPTH, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    expect_st("overflow_sticky", WIDTH'(DEPTH), DEPTH, 2, 1'b0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
